// File: rtl/bouncing_box_gen.sv
// Pixel-colour stage: draws a square box that moves diagonally and bounces off the
// edges of the active area, stepping once every FRAME_DIV frames.
module bouncing_box_gen #(
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter int          BOX_SIZE  = 32,
    parameter int          STEP      = 2,
    parameter int          FRAME_DIV = 1,
    parameter int          INIT_X    = 0,
    parameter int          INIT_Y    = 0,
    parameter logic [11:0] BOX_COLOR = 12'hF00,
    parameter logic [11:0] BG_COLOR  = 12'h00F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic [9:0] x_loc,
    input  logic [9:0] y_loc,
    input  logic       video_on,
    input  logic       run,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic [9:0] box_x,
    output logic [9:0] box_y,
    output logic       frame_end
);

    localparam int X_MAX = H_ACTIVE - BOX_SIZE;
    localparam int Y_MAX = V_ACTIVE - BOX_SIZE;
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    // bit 1 = horizontal direction (1 = left), bit 0 = vertical direction (1 = up)
    typedef enum logic [1:0] {
        DR = 2'b00,
        DL = 2'b10,
        UR = 2'b01,
        UL = 2'b11
    } dir_t;

    dir_t             state_r;
    dir_t             next_state_s;
    logic [9:0]       box_x_r;
    logic [9:0]       box_y_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [11:0]      colour_r;
    logic             frame_end_r;

    logic             frame_end_s;
    logic             move_due_s;
    logic             in_box_s;
    logic [11:0]      colour_s;
    logic             going_left_s;
    logic             going_up_s;
    logic             next_left_s;
    logic             next_up_s;
    logic [9:0]       next_x_s;
    logic [9:0]       next_y_s;

    // Pixel classification and frame-boundary detection, 11-bit so edges never wrap.
    always_comb begin
        in_box_s = ({1'b0, x_loc} >= {1'b0, box_x_r}) &&
                   ({1'b0, x_loc} <  ({1'b0, box_x_r} + 11'(BOX_SIZE))) &&
                   ({1'b0, y_loc} >= {1'b0, box_y_r}) &&
                   ({1'b0, y_loc} <  ({1'b0, box_y_r} + 11'(BOX_SIZE)));
        if (video_on) begin
            colour_s = in_box_s ? BOX_COLOR : BG_COLOR;
        end else begin
            colour_s = 12'h000;
        end
        frame_end_s = pix_en && video_on &&
                      (x_loc == 10'(H_ACTIVE - 1)) && (y_loc == 10'(V_ACTIVE - 1));
        move_due_s  = frame_end_s && (div_cnt_r == DIV_W'(FRAME_DIV - 1));
    end

    // Next box position and direction; each axis clamps at its limit and reverses.
    always_comb begin
        case (state_r)
            DR:      begin going_left_s = 1'b0; going_up_s = 1'b0; end
            DL:      begin going_left_s = 1'b1; going_up_s = 1'b0; end
            UR:      begin going_left_s = 1'b0; going_up_s = 1'b1; end
            UL:      begin going_left_s = 1'b1; going_up_s = 1'b1; end
            default: begin going_left_s = 1'b0; going_up_s = 1'b0; end
        endcase

        if (!going_left_s) begin
            if (({1'b0, box_x_r} + 11'(STEP)) >= 11'(X_MAX)) begin
                next_x_s    = 10'(X_MAX);
                next_left_s = 1'b1;
            end else begin
                next_x_s    = box_x_r + 10'(STEP);
                next_left_s = 1'b0;
            end
        end else begin
            if (box_x_r <= 10'(STEP)) begin
                next_x_s    = 10'd0;
                next_left_s = 1'b0;
            end else begin
                next_x_s    = box_x_r - 10'(STEP);
                next_left_s = 1'b1;
            end
        end

        if (!going_up_s) begin
            if (({1'b0, box_y_r} + 11'(STEP)) >= 11'(Y_MAX)) begin
                next_y_s  = 10'(Y_MAX);
                next_up_s = 1'b1;
            end else begin
                next_y_s  = box_y_r + 10'(STEP);
                next_up_s = 1'b0;
            end
        end else begin
            if (box_y_r <= 10'(STEP)) begin
                next_y_s  = 10'd0;
                next_up_s = 1'b0;
            end else begin
                next_y_s  = box_y_r - 10'(STEP);
                next_up_s = 1'b1;
            end
        end

        case ({next_left_s, next_up_s})
            2'b00:   next_state_s = DR;
            2'b10:   next_state_s = DL;
            2'b01:   next_state_s = UR;
            2'b11:   next_state_s = UL;
            default: next_state_s = DR;
        endcase
    end

    // Colour pipeline, frame divider and direction FSM; the last pixel of a frame
    // is coloured from the old position while the move lands on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= DR;
            box_x_r     <= 10'(INIT_X);
            box_y_r     <= 10'(INIT_Y);
            div_cnt_r   <= '0;
            colour_r    <= 12'h000;
            frame_end_r <= 1'b0;
        end else begin
            frame_end_r <= frame_end_s;
            if (pix_en) begin
                colour_r <= colour_s;
                if (move_due_s) begin
                    div_cnt_r <= '0;
                    if (run) begin
                        box_x_r <= next_x_s;
                        box_y_r <= next_y_s;
                        state_r <= next_state_s;
                    end
                end else if (frame_end_s) begin
                    div_cnt_r <= div_cnt_r + DIV_W'(1);
                end
            end
        end
    end

    assign red       = colour_r[11:8];
    assign green     = colour_r[7:4];
    assign blue      = colour_r[3:0];
    assign box_x     = box_x_r;
    assign box_y     = box_y_r;
    assign frame_end = frame_end_r;

endmodule
